param_stack: RTL and testbench
==============================

// Module: param_stack
// PURPOSE
//  Parametrised operand stack for the tinycpu family; successor to the fixed
//  16-bit stack behind qtop. Generalised in WIDTH and DEPTH, with count/full/
//  empty status, multi-operand ops (POP2, DUP, SWAP, REPL) and a sticky error.
//  Sits between the decoder/ALU and dbus; qtop/qnext feed ALU operands directly.
// PARAMETERS
//  WIDTH  16  data word width in bits
//  DEPTH  8   number of entries, >=2 (any integer, not only powers of 2)
//  CW     $clog2(DEPTH+1)  count width (localparam, derived)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      asynchronous, active-low; 0 = reset asserted
//  op       in   3      0 NOP,1 PUSH,2 POP,3 POP2,4 DUP,5 SWAP,6 REPL,7 CLEAR
//  load     in   WIDTH  data for PUSH, POP2 and REPL
//  clr_err  in   1      clears sticky err (synchronous)
//  qtop     out  WIDTH  top entry (0 when count==0)
//  qnext    out  WIDTH  second entry (0 when count<2)
//  count    out  CW     entries held, 0..DEPTH
//  empty    out  1      count==0
//  full     out  1      count==DEPTH
//  err      out  1      sticky: set by any illegal op
// BEHAVIOUR
//  Reset (reset==0, async): all entries, count and err are 0; qtop=qnext=0,
//    empty=1, full=0. Holds while reset==0; a reset mid-op discards the op.
//  All updates take effect on the rising clk edge; outputs reflect the new
//    state in the same cycle after the edge (zero-cycle read latency; qtop,
//    qnext, empty and full are combinational from the stored state).
//  Ops (T=top, N=next):
//    NOP   no change.
//    PUSH  legal if !full: new T=load, old T->N, count+1.
//    POP   legal if count>=1: T discarded, count-1.
//    POP2  legal if count>=2: T,N removed, load pushed; net count-1. This is
//          the ALU binary-op writeback (load = f(qnext,qtop)).
//    DUP   legal if count>=1 && !full: T copied, count+1.
//    SWAP  legal if count>=2: T<->N, count unchanged.
//    REPL  legal if count>=1: T=load (unary-op writeback), count unchanged.
//    CLEAR always legal: count=0, qtop=qnext=0; err is unaffected.
//  Illegal op (overflow/underflow): storage and count unchanged; err=1 on
//    the same edge.
//  err is sticky until clr_err=1 at an edge; if clr_err coincides with a new
//    illegal op, err stays 1 (set wins).
//  Entries at or above count are don't-care internally, never visible on
//    outputs.
//  No wrap-around: count saturates at DEPTH and 0 via the legality rules.
// TESTING
//  1 Reset: reset=0 with pushes active -> qtop=0, count=0, empty=1, err=0;
//    release -> first PUSH 16'h0002 gives qtop=2, count=1.
//  2 Fill: DEPTH=8, PUSH 1..8 -> full=1, qtop=8, qnext=7; 9th PUSH 9 ->
//    err=1, qtop=8, count=8.
//  3 Underflow: empty, POP -> err=1, count=0; clr_err -> err=0; POP2 with
//    count=1 -> err=1, qtop unchanged.
//  4 ALU path: PUSH 2, PUSH 5, POP2 load=7 -> qtop=7, count=1; REPL 0xFFF8
//    -> qtop=16'hFFF8.
//  5 DUP/SWAP: PUSH 3, PUSH 4, SWAP -> qtop=3, qnext=4; DUP -> qtop=3,
//    qnext=3, count=3; CLEAR -> empty=1.
//  6 Params: rerun 2-4 with WIDTH=8, DEPTH=5 (non-power-of-2) -> full at 5,
//    count width 3.

Source files
------------

// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack
//   Parametrised operand stack for the tinycpu family. Holds up to DEPTH words
//   of WIDTH bits, exposes the top two entries directly to the ALU, and
//   supports multi-operand ops (POP2, DUP, SWAP, REPL) plus a sticky error
//   flag for overflow/underflow.
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-low (0 = reset asserted)
//   op       in   3      0 NOP,1 PUSH,2 POP,3 POP2,4 DUP,5 SWAP,6 REPL,7 CLEAR
//   load     in   WIDTH  data for PUSH, POP2 and REPL
//   clr_err  in   1      synchronous clear of the sticky error
//   qtop     out  WIDTH  top entry (0 when empty)
//   qnext    out  WIDTH  second entry (0 when fewer than two entries)
//   count    out  CW     number of entries held, 0..DEPTH
//   empty    out  1      count == 0
//   full     out  1      count == DEPTH
//   err      out  1      sticky, set by any illegal op
// ---------------------------------------------------------------------------
module param_stack #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] load,
   input  logic             clr_err,
   output logic [WIDTH-1:0] qtop,
   output logic [WIDTH-1:0] qnext,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_POP2  = 3'd3,
      OP_DUP   = 3'd4,
      OP_SWAP  = 3'd5,
      OP_REPL  = 3'd6,
      OP_CLEAR = 3'd7
   } op_e;

   // Entry 0 is the bottom of the stack; the top lives at r_count-1.
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_err;

   op_e              w_op;
   logic [AW-1:0]    w_topIdx;
   logic [AW-1:0]    w_nextIdx;
   logic [AW-1:0]    w_pushIdx;
   logic             w_hasOne;
   logic             w_hasTwo;
   logic             w_full;
   logic             w_legal;
   logic [CW-1:0]    w_nextCount;

   assign w_op      = op_e'(op);
   assign w_hasOne  = (r_count != '0);
   assign w_hasTwo  = (r_count >= CW'(2));
   assign w_full    = (r_count == CW'(DEPTH));

   // Index arithmetic wraps when the stack is nearly empty or full; those
   // indices are only used when the op is legal or the output is masked.
   assign w_topIdx  = AW'(r_count - CW'(1));
   assign w_nextIdx = AW'(r_count - CW'(2));
   assign w_pushIdx = AW'(r_count);

   // Legality and resulting count for the requested op.
   always_comb begin
      w_legal     = 1'b1;
      w_nextCount = r_count;
      case (w_op)
         OP_NOP: ;
         OP_PUSH: begin
            w_legal     = !w_full;
            w_nextCount = r_count + CW'(1);
         end
         OP_POP: begin
            w_legal     = w_hasOne;
            w_nextCount = r_count - CW'(1);
         end
         OP_POP2: begin
            w_legal     = w_hasTwo;
            w_nextCount = r_count - CW'(1);
         end
         OP_DUP: begin
            w_legal     = w_hasOne && !w_full;
            w_nextCount = r_count + CW'(1);
         end
         OP_SWAP:  w_legal = w_hasTwo;
         OP_REPL:  w_legal = w_hasOne;
         OP_CLEAR: w_nextCount = '0;
         default: ;
      endcase
   end

   // Storage, count and sticky error. Illegal ops leave storage and count
   // untouched; a coincident illegal op beats clr_err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_legal) begin
            r_count <= w_nextCount;
            case (w_op)
               OP_PUSH: r_mem[w_pushIdx] <= load;
               OP_POP2: r_mem[w_nextIdx] <= load;
               OP_DUP:  r_mem[w_pushIdx] <= r_mem[w_topIdx];
               OP_SWAP: begin
                  r_mem[w_topIdx]  <= r_mem[w_nextIdx];
                  r_mem[w_nextIdx] <= r_mem[w_topIdx];
               end
               OP_REPL: r_mem[w_topIdx] <= load;
               default: ;
            endcase
         end
         if (!w_legal) begin
            r_err <= 1'b1;
         end else if (clr_err) begin
            r_err <= 1'b0;
         end
      end
   end

   // Entries at or above count are stale, so outputs are masked by count.
   assign qtop  = w_hasOne ? r_mem[w_topIdx]  : '0;
   assign qnext = w_hasTwo ? r_mem[w_nextIdx] : '0;
   assign count = r_count;
   assign empty = !w_hasOne;
   assign full  = w_full;
   assign err   = r_err;

endmodule

// File: tb/tb_param_stack.sv
// ---------------------------------------------------------------------------
// tb_param_stack
//   Self-checking bench for param_stack. Two instances run side by side: the
//   default 16-bit/8-deep stack and an 8-bit/5-deep stack. A queue-based
//   reference model tracks each one and every output is compared after each
//   clock edge, with directed scenarios followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_param_stack;

   typedef logic [15:0] stk_t[$];

   logic        clk;
   logic        rst_n;

   logic [2:0]  opA;
   logic [15:0] loadA;
   logic        clrA;
   logic [15:0] qtopA;
   logic [15:0] qnextA;
   logic [3:0]  countA;
   logic        emptyA;
   logic        fullA;
   logic        errA;

   logic [2:0]  opB;
   logic [7:0]  loadB;
   logic        clrB;
   logic [7:0]  qtopB;
   logic [7:0]  qnextB;
   logic [2:0]  countB;
   logic        emptyB;
   logic        fullB;
   logic        errB;

   int          tests;
   int          failed;

   stk_t        mA;
   stk_t        mB;
   logic        eA;
   logic        eB;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, POP2 = 3'd3,
                          DUP = 3'd4, SWAP = 3'd5, REPL = 3'd6, CLEAR = 3'd7;

   param_stack #(.WIDTH(16), .DEPTH(8)) dutA (
      .clk(clk), .reset(rst_n), .op(opA), .load(loadA), .clr_err(clrA),
      .qtop(qtopA), .qnext(qnextA), .count(countA), .empty(emptyA),
      .full(fullA), .err(errA)
   );

   param_stack #(.WIDTH(8), .DEPTH(5)) dutB (
      .clk(clk), .reset(rst_n), .op(opB), .load(loadB), .clr_err(clrB),
      .qtop(qtopB), .qnext(qnextB), .count(countB), .empty(emptyB),
      .full(fullB), .err(errB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the queue's last element is the top of the stack.
   task automatic modelOp(inout stk_t s, inout logic e, input int depth,
                          input logic [15:0] mask, input logic [2:0] o,
                          input logic [15:0] ld, input logic c);
      logic        ok;
      logic [15:0] t;
      int          n;
      ok = 1'b1;
      n  = s.size();
      case (o)
         PUSH:  if (n < depth) s.push_back(ld & mask); else ok = 1'b0;
         POP:   if (n >= 1) void'(s.pop_back()); else ok = 1'b0;
         POP2:  if (n >= 2) begin
                   void'(s.pop_back());
                   void'(s.pop_back());
                   s.push_back(ld & mask);
                end else ok = 1'b0;
         DUP:   if (n >= 1 && n < depth) s.push_back(s[n-1]); else ok = 1'b0;
         SWAP:  if (n >= 2) begin
                   t = s[n-1];
                   s[n-1] = s[n-2];
                   s[n-2] = t;
                end else ok = 1'b0;
         REPL:  if (n >= 1) s[n-1] = ld & mask; else ok = 1'b0;
         CLEAR: s.delete();
         default: ;
      endcase
      if (!ok) e = 1'b1;
      else if (c) e = 1'b0;
   endtask

   function automatic logic [15:0] topOf(input stk_t s);
      return (s.size() >= 1) ? s[s.size()-1] : 16'h0;
   endfunction

   function automatic logic [15:0] nextOf(input stk_t s);
      return (s.size() >= 2) ? s[s.size()-2] : 16'h0;
   endfunction

   // Single comparison point: counts it and reports on mismatch.
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare every output of both instances against the model.
   task automatic checkOutput(input string tag);
      chk({tag, " A.qtop"},  qtopA, topOf(mA));
      chk({tag, " A.qnext"}, qnextA, nextOf(mA));
      chk({tag, " A.count"}, {12'h0, countA}, 16'(mA.size()));
      chk({tag, " A.empty"}, {15'h0, emptyA}, {15'h0, mA.size() == 0});
      chk({tag, " A.full"},  {15'h0, fullA}, {15'h0, mA.size() == 8});
      chk({tag, " A.err"},   {15'h0, errA}, {15'h0, eA});
      chk({tag, " B.qtop"},  {8'h0, qtopB}, topOf(mB));
      chk({tag, " B.qnext"}, {8'h0, qnextB}, nextOf(mB));
      chk({tag, " B.count"}, {13'h0, countB}, 16'(mB.size()));
      chk({tag, " B.empty"}, {15'h0, emptyB}, {15'h0, mB.size() == 0});
      chk({tag, " B.full"},  {15'h0, fullB}, {15'h0, mB.size() == 5});
      chk({tag, " B.err"},   {15'h0, errB}, {15'h0, eB});
   endtask

   // One clock cycle: drive both instances, clock, update model, compare.
   task automatic applyStimulus(input string tag,
                                input logic [2:0] oa, input logic [15:0] la, input logic ca,
                                input logic [2:0] ob, input logic [15:0] lb, input logic cb);
      @(negedge clk);
      opA = oa; loadA = la; clrA = ca;
      opB = ob; loadB = lb[7:0]; clrB = cb;
      @(posedge clk);
      #1;
      modelOp(mA, eA, 8, 16'hFFFF, oa, la, ca);
      modelOp(mB, eB, 5, 16'h00FF, ob, lb, cb);
      checkOutput(tag);
   endtask

   task automatic stepA(input string tag, input logic [2:0] o, input logic [15:0] l, input logic c);
      applyStimulus(tag, o, l, c, NOP, 16'h0, 1'b0);
   endtask

   task automatic stepB(input string tag, input logic [2:0] o, input logic [15:0] l, input logic c);
      applyStimulus(tag, NOP, 16'h0, 1'b0, o, l, c);
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      eA = 1'b0;
      eB = 1'b0;
      rst_n = 1'b0;
      opA = PUSH; loadA = 16'h1234; clrA = 1'b0;
      opB = PUSH; loadB = 8'h34;    clrB = 1'b0;

      // Reset held with pushes requested: nothing may be stored.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset");
      chk("reset emptyA", {15'h0, emptyA}, 16'h1);
      @(negedge clk);
      rst_n = 1'b1;
      opA = NOP; opB = NOP;

      stepA("push2", PUSH, 16'h0002, 1'b0);
      chk("push2 qtop", qtopA, 16'h0002);
      chk("push2 count", {12'h0, countA}, 16'd1);
      stepA("push3", PUSH, 16'h0003, 1'b0);
      stepA("push4", PUSH, 16'h0004, 1'b0);

      // Asynchronous reset mid-cycle discards the pending push.
      @(negedge clk);
      opA = PUSH; loadA = 16'h0009;
      #2 rst_n = 1'b0;
      #1;
      mA.delete(); mB.delete(); eA = 1'b0; eB = 1'b0;
      checkOutput("async reset");
      @(posedge clk);
      #1;
      checkOutput("reset held");
      @(negedge clk);
      rst_n = 1'b1;
      opA = NOP;

      // Fill to DEPTH, then overflow.
      for (int i = 1; i <= 8; i++) stepA("fill", PUSH, 16'(i), 1'b0);
      chk("fill full", {15'h0, fullA}, 16'h1);
      chk("fill qtop", qtopA, 16'd8);
      chk("fill qnext", qnextA, 16'd7);
      stepA("overflow", PUSH, 16'd9, 1'b0);
      chk("overflow err", {15'h0, errA}, 16'h1);
      chk("overflow qtop", qtopA, 16'd8);
      chk("overflow count", {12'h0, countA}, 16'd8);

      // Underflow, sticky error and set-beats-clear.
      stepA("clear", CLEAR, 16'h0, 1'b1);
      stepA("pop empty", POP, 16'h0, 1'b0);
      chk("pop empty err", {15'h0, errA}, 16'h1);
      stepA("pop+clr", POP, 16'h0, 1'b1);
      chk("set wins", {15'h0, errA}, 16'h1);
      stepA("clr_err", NOP, 16'h0, 1'b1);
      chk("clr_err err", {15'h0, errA}, 16'h0);
      stepA("push abcd", PUSH, 16'hABCD, 1'b0);
      stepA("pop2 one", POP2, 16'h1111, 1'b0);
      chk("pop2 one err", {15'h0, errA}, 16'h1);
      chk("pop2 one qtop", qtopA, 16'hABCD);

      // ALU writeback path.
      stepA("clear", CLEAR, 16'h0, 1'b1);
      stepA("alu push2", PUSH, 16'd2, 1'b0);
      stepA("alu push5", PUSH, 16'd5, 1'b0);
      stepA("alu pop2", POP2, 16'd7, 1'b0);
      chk("alu qtop", qtopA, 16'd7);
      chk("alu count", {12'h0, countA}, 16'd1);
      stepA("alu repl", REPL, 16'hFFF8, 1'b0);
      chk("repl qtop", qtopA, 16'hFFF8);

      // DUP / SWAP / CLEAR.
      stepA("clear", CLEAR, 16'h0, 1'b0);
      stepA("ds push3", PUSH, 16'd3, 1'b0);
      stepA("ds push4", PUSH, 16'd4, 1'b0);
      stepA("swap", SWAP, 16'h0, 1'b0);
      chk("swap qtop", qtopA, 16'd3);
      chk("swap qnext", qnextA, 16'd4);
      stepA("dup", DUP, 16'h0, 1'b0);
      chk("dup qnext", qnextA, 16'd3);
      chk("dup count", {12'h0, countA}, 16'd3);
      stepA("clear", CLEAR, 16'h0, 1'b0);
      chk("clear empty", {15'h0, emptyA}, 16'h1);

      // Narrow, non-power-of-2 instance.
      for (int i = 1; i <= 5; i++) stepB("B fill", PUSH, 16'(i), 1'b0);
      chk("B full", {15'h0, fullB}, 16'h1);
      stepB("B overflow", PUSH, 16'd6, 1'b0);
      chk("B overflow qtop", {8'h0, qtopB}, 16'd5);
      chk("B overflow count", {13'h0, countB}, 16'd5);
      stepB("B clear", CLEAR, 16'h0, 1'b1);
      stepB("B pop empty", POP, 16'h0, 1'b0);
      stepB("B clr", NOP, 16'h0, 1'b1);
      stepB("B push2", PUSH, 16'd2, 1'b0);
      stepB("B pop2 one", POP2, 16'h11, 1'b0);
      stepB("B push5", PUSH, 16'd5, 1'b0);
      stepB("B pop2", POP2, 16'd7, 1'b0);
      stepB("B repl", REPL, 16'hFFF8, 1'b0);
      chk("B repl qtop", {8'h0, qtopB}, 16'h00F8);

      // Randomized ops on both instances, pushes weighted up.
      for (int n = 0; n < 400; n++) begin
         logic [2:0] oa;
         logic [2:0] ob;
         int ra;
         int rb;
         ra = $urandom_range(0, 11);
         rb = $urandom_range(0, 11);
         oa = (ra >= 7) ? ((ra == 11) ? CLEAR : PUSH) : 3'(ra);
         ob = (rb >= 7) ? ((rb == 11) ? CLEAR : PUSH) : 3'(rb);
         applyStimulus("random", oa, 16'($urandom), ($urandom_range(0, 7) == 0),
                       ob, 16'($urandom), ($urandom_range(0, 7) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
